// File: rtl/mm_pkg.sv
// Shared types and sizing helpers for the systolic matrix-multiply datapath.
package mm_pkg;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} feeder_state_e;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefN         = 4;
  localparam int unsigned DefKMax      = 255;

  function automatic int unsigned k_width(input int unsigned k_max);
    return $clog2(k_max + 1);
  endfunction

  // Step counter must hold K_MAX + 2N - 3 without wrapping.
  function automatic int unsigned step_width(input int unsigned k_max, input int unsigned n);
    return $clog2(k_max + 2 * n - 2);
  endfunction

endpackage

// File: rtl/skew_line.sv
// Enabled shift register with synchronous clear; one per array edge lane.
module skew_line #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int unsigned s = 0; s < DEPTH; s++) stage_q[s] <= '0;
    end else if (en) begin
      stage_q[0] <= d;
      for (int unsigned s = 1; s < DEPTH; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Skews A columns / B rows into an N x N MAC array, then drains zeros until C is final.
// Optional stall counter port enabled by defining FEEDER_PERF_CNT_EN.
module systolic_feeder
  import mm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned N          = DefN,
  parameter int unsigned K_MAX      = DefKMax,
  parameter int unsigned KW         = k_width(K_MAX)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic [KW-1:0]           k_len_i,
  output logic                    busy_o,
  output logic                    done_o,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [N*DATA_WIDTH-1:0] a_col_i,
  input  logic [N*DATA_WIDTH-1:0] b_row_i,
  output logic                    ld_o,
  output logic [N*DATA_WIDTH-1:0] a_edge_o,
  output logic [N*DATA_WIDTH-1:0] b_edge_o,
  output logic [2*N-2:0]          clr_n_o
`ifdef FEEDER_PERF_CNT_EN
  ,
  output logic [31:0]             stall_cnt_o
`endif
);

  localparam int unsigned TW = step_width(K_MAX, N);

  feeder_state_e     state_q;
  logic [TW-1:0]     t_q;
  logic [TW-1:0]     k_q;
  logic [KW:0]       k_ext;
  logic [TW-1:0]     k_sat;
  logic              start_job;
  logic              adv;
  logic              last_beat;
  logic              last_drain;
  logic [N*DATA_WIDTH-1:0] a_src;
  logic [N*DATA_WIDTH-1:0] b_src;

  assign k_ext      = {1'b0, k_len_i};
  assign k_sat      = (k_ext > (KW+1)'(K_MAX)) ? TW'(K_MAX) : TW'(k_len_i);
  assign start_job  = (state_q == IDLE) && start_i;
  assign adv        = ((state_q == FEED) && in_valid_i) || (state_q == DRAIN);
  assign last_beat  = (t_q == k_q - TW'(1));
  assign last_drain = (t_q == k_q + TW'(2 * N - 3));

  assign busy_o     = (state_q != IDLE);
  assign in_ready_o = (state_q == FEED);

  // Zeros are injected during DRAIN so every job leaves trailing zeros in the array.
  assign a_src = (state_q == FEED) ? a_col_i : '0;
  assign b_src = (state_q == FEED) ? b_row_i : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      k_q     <= '0;
      ld_o    <= 1'b0;
      done_o  <= 1'b0;
      clr_n_o <= '1;
    end else begin
      ld_o   <= adv;
      done_o <= (state_q == DONE);
      for (int d = 0; d < 2 * N - 1; d++) clr_n_o[d] <= !(adv && (t_q == TW'(d)));
      if (adv) t_q <= t_q + TW'(1);
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            t_q     <= '0;
            k_q     <= k_sat;
            state_q <= (k_sat == '0) ? DONE : FEED;
          end
        end
        FEED:    if (in_valid_i && last_beat) state_q <= DRAIN;
        DRAIN:   if (last_drain) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_line #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (g + 1)
    ) u_a_skew (
      .clk  (clk),
      .reset(reset),
      .clr  (start_job),
      .en   (adv),
      .d    (a_src[g*DATA_WIDTH +: DATA_WIDTH]),
      .q    (a_edge_o[g*DATA_WIDTH +: DATA_WIDTH])
    );
    skew_line #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (g + 1)
    ) u_b_skew (
      .clk  (clk),
      .reset(reset),
      .clr  (start_job),
      .en   (adv),
      .d    (b_src[g*DATA_WIDTH +: DATA_WIDTH]),
      .q    (b_edge_o[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

`ifdef FEEDER_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || start_job) begin
      stall_cnt_o <= '0;
    end else if ((state_q == FEED) && !in_valid_i && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`else
  // No stall counter in this build.
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench: feeder driving a behavioural N x N MAC array, checked against a plain matrix product.
module tb_systolic_feeder;

  localparam int DW   = 8;
  localparam int N    = 4;
  localparam int KMAX = 255;
  localparam int KW   = 8;
  localparam int ND   = 2 * N - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            start_i;
  logic [KW-1:0]   k_len_i;
  logic            busy_o;
  logic            done_o;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [N*DW-1:0] a_col_i;
  logic [N*DW-1:0] b_row_i;
  logic            ld_o;
  logic [N*DW-1:0] a_edge_o;
  logic [N*DW-1:0] b_edge_o;
  logic [ND-1:0]   clr_n_o;
`ifdef FEEDER_PERF_CNT_EN
  logic [31:0]     stall_cnt_o;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int exp_t       = 0;

  int unsigned ga [N][KMAX+1];
  int unsigned gb [KMAX+1][N];

  logic [DW-1:0]   ma [N][N];
  logic [DW-1:0]   mb [N][N];
  logic [DW-1:0]   a_in_w [N][N];
  logic [DW-1:0]   b_in_w [N][N];
  logic [2*DW-1:0] mc [N][N];
  logic [2*DW-1:0] mc_saved [N][N];

  systolic_feeder #(
    .DATA_WIDTH(DW),
    .N         (N),
    .K_MAX     (KMAX),
    .KW        (KW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_i),
    .k_len_i    (k_len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .a_col_i    (a_col_i),
    .b_row_i    (b_row_i),
    .ld_o       (ld_o),
    .a_edge_o   (a_edge_o),
    .b_edge_o   (b_edge_o),
    .clr_n_o    (clr_n_o)
`ifdef FEEDER_PERF_CNT_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Array of MACs: a flows east, b flows south, accumulator cleared per diagonal.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in_w[i][0] = a_edge_o[i*DW +: DW];
      b_in_w[0][i] = b_edge_o[i*DW +: DW];
      for (int j = 1; j < N; j++) begin
        a_in_w[i][j] = ma[i][j-1];
        b_in_w[j][i] = mb[j-1][i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_o) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          ma[i][j] <= a_in_w[i][j];
          mb[i][j] <= b_in_w[i][j];
          mc[i][j] <= (clr_n_o[i+j] ? mc[i][j] : '0)
                      + 16'(a_in_w[i][j]) * 16'(b_in_w[i][j]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each advance clears exactly one diagonal, the d-th advance clears diagonal d.
  task automatic chk_ld(input string tag, input logic exp_ld);
    logic [ND-1:0] eclr;
    eclr = '1;
    if (exp_ld && exp_t <= ND - 1) eclr[exp_t] = 1'b0;
    chk(tag, ld_o, exp_ld);
    chk({tag, "_clr"}, clr_n_o, eclr);
    if (exp_ld) exp_t++;
  endtask

  function automatic logic [2*DW-1:0] gold(input int i, input int j, input int k);
    int unsigned sum;
    sum = 0;
    for (int kk = 0; kk < k; kk++) sum += ga[i][kk] * gb[kk][j];
    return 16'(sum);
  endfunction

  task automatic fill(input int k, input bit all_max);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < N; i++) begin
        ga[i][kk] = all_max ? 255 : $urandom_range(0, 255);
        gb[kk][i] = all_max ? 255 : $urandom_range(0, 255);
      end
    end
  endtask

  task automatic run_job(input int k, input int mode, input bit poke, input bit abort);
    int   beat;
    int   stalls;
    int   budget;
    logic v;
    beat   = 0;
    stalls = 0;
    budget = 0;
    exp_t  = 0;
    start_i    = 1'b1;
    k_len_i    = KW'(k);
    in_valid_i = 1'b0;
    step();
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1'b1);
    chk("done_low_after_start", done_o, 1'b0);
    if (k == 0) begin
      chk_ld("k0_no_ld", 1'b0);
      chk("k0_ready_low", in_ready_o, 1'b0);
      step();
      chk("k0_done", done_o, 1'b1);
      chk_ld("k0_no_ld2", 1'b0);
      chk("k0_idle", busy_o, 1'b0);
      return;
    end
    while (beat < k) begin
      chk("feed_ready", in_ready_o, 1'b1);
      case (mode)
        0:       v = 1'b1;
        1:       v = !(beat == 1 && stalls < 3);
        default: v = ($urandom_range(0, 9) >= 3);
      endcase
      in_valid_i = v;
      for (int i = 0; i < N; i++) begin
        a_col_i[i*DW +: DW] = DW'(ga[i][beat]);
        b_row_i[i*DW +: DW] = DW'(gb[beat][i]);
      end
      step();
      if (v) beat++;
      else stalls++;
      chk_ld("feed_ld", v);
      budget++;
      if (budget > 4000) begin
        chk("feed_budget", beat, k);
        break;
      end
    end
    in_valid_i = 1'b0;
    a_col_i    = '0;
    b_row_i    = '0;
    chk("drain_ready_low", in_ready_o, 1'b0);
    for (int d = 0; d < 2 * N - 2; d++) begin
      if (abort && d == 1) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_ld", ld_o, 1'b0);
        chk("rst_clr", clr_n_o, {ND{1'b1}});
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ready", in_ready_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_a_edge", a_edge_o, '0);
        chk("rst_b_edge", b_edge_o, '0);
        return;
      end
      if (poke) begin
        start_i = 1'b1;
        k_len_i = KW'(7);
      end
      step();
      chk_ld("drain_ld", 1'b1);
      chk("drain_done_low", done_o, 1'b0);
    end
    start_i = 1'b0;
    chk("done_state_busy", busy_o, 1'b1);
    step();
    chk("done_pulse", done_o, 1'b1);
    chk_ld("done_no_ld", 1'b0);
    chk("done_idle", busy_o, 1'b0);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) chk("c_elem", mc[i][j], gold(i, j, k));
    end
`ifdef FEEDER_PERF_CNT_EN
    chk("stall_cnt", stall_cnt_o, stalls);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    k_len_i    = '0;
    a_col_i    = '0;
    b_row_i    = '0;
    repeat (3) step();
    chk("reset_ld", ld_o, 1'b0);
    chk("reset_done", done_o, 1'b0);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_ready", in_ready_o, 1'b0);
    chk("reset_clr", clr_n_o, {ND{1'b1}});
    chk("reset_a_edge", a_edge_o, '0);
    chk("reset_b_edge", b_edge_o, '0);
    reset = 1'b0;
    step();
    chk("idle_ld", ld_o, 1'b0);

    fill(2, 1'b0);
    run_job(2, 0, 1'b0, 1'b0);
    run_job(2, 1, 1'b0, 1'b0);

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mc_saved[i][j] = mc[i][j];
    run_job(0, 0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) chk("k0_array_kept", mc[i][j], mc_saved[i][j]);

    fill(3, 1'b0);
    run_job(3, 0, 1'b0, 1'b1);
    fill(4, 1'b0);
    run_job(4, 2, 1'b1, 1'b0);
    fill(4, 1'b0);
    run_job(4, 0, 1'b1, 1'b0);

    fill(KMAX, 1'b1);
    run_job(KMAX, 0, 1'b0, 1'b0);
    chk("kmax_c00_const", mc[0][0], 16'd767);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
